// File: rtl/wb_mem_streamer.sv
// wb_mem_streamer: Wishbone-master DMA that reads a memory region in incrementing
// bursts and emits the words as a 32-bit valid/ready stream. A small Wishbone
// slave holds CTRL/STATUS/ADDR/LENGTH/COUNT and raises irq_o on completion.
// Optional: define MEM_STREAMER_LAST_EN to add m_last_o, which marks the final
// word of a transfer; the FIFO then carries that flag as a 33rd bit.
module wb_mem_streamer #(
    parameter int WB_AW     = 32,
    parameter int FIFO_AW   = 6,
    parameter int BURST_LEN = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [4:0]       wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic             wbs_we_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [2:0]       wbm_cti_o,
    output logic [1:0]       wbm_bte_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic [31:0]      m_data_o,
    output logic             m_valid_o,
`ifdef MEM_STREAMER_LAST_EN
    output logic             m_last_o,
`endif
    input  logic             m_ready_i,
    output logic             irq_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(BURST_LEN) + 1;
`ifdef MEM_STREAMER_LAST_EN
    localparam int FW = 33;
`else
    localparam int FW = 32;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_DRAIN} state_t;
    state_t state_q, state_d;

    logic              ack_q;
    logic [31:0]       rdata_q;
    logic              irq_en_q, done_q, irq_q;
    logic [WB_AW-1:0]  cfg_addr_q, adr_q;
    logic [31:0]       cfg_len_q, remaining_q, count_q;
    logic [BW-1:0]     beats_q;
    logic              cyc_q;
    logic [FW-1:0]     mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]     out_q;
    logic              out_valid_q;

    logic              busy, req, wr_en, start;
    logic [2:0]        reg_sel;
    logic [31:0]       burst_n, fifo_free;
    logic [FIFO_AW:0]  fifo_cnt;
    logic              fifo_empty, push, pop, beat_ack, xfer;
    logic              launch, begin_xfer, set_done;
    logic [FW-1:0]     push_data;
    logic              unused_bits;

    assign busy       = (state_q != S_IDLE);
    assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_en      = req & wbs_we_i;
    assign reg_sel    = wbs_adr_i[4:2];
    assign start      = wr_en && (reg_sel == 3'd0) && wbs_dat_i[0] && !busy;
    assign burst_n    = (remaining_q < 32'(BURST_LEN)) ? remaining_q : 32'(BURST_LEN);
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_free  = 32'(DEPTH) - 32'(fifo_cnt);
    assign fifo_empty = (fifo_cnt == '0);
    assign beat_ack   = (state_q == S_BURST) && wbm_ack_i;
    assign push       = beat_ack;
    assign pop        = !fifo_empty && (!out_valid_q || m_ready_i);
    assign xfer       = out_valid_q && m_ready_i;
    assign unused_bits = ^{wbs_adr_i[1:0], burst_n[31:BW]};

`ifdef MEM_STREAMER_LAST_EN
    assign push_data = {(remaining_q == 32'd1), wbm_dat_i};
    assign m_last_o  = out_q[32];
`else
    assign push_data = wbm_dat_i;
`endif

    assign wbs_dat_o = rdata_q;
    assign wbs_ack_o = ack_q;
    assign wbm_adr_o = adr_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;
    assign wbm_bte_o = 2'b00;
    assign wbm_cti_o = !cyc_q ? 3'b000 : ((beats_q == BW'(1)) ? 3'b111 : 3'b010);
    assign m_data_o  = out_q[31:0];
    assign m_valid_o = out_valid_q;
    assign irq_o     = irq_q;

    // Next-state and one-cycle control strobes for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        begin_xfer = 1'b0;
        set_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len_q == 32'd0) begin
                        set_done = 1'b1;
                    end else begin
                        begin_xfer = 1'b1;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Reserve room for the whole burst so acks can always be stored.
                if (burst_n <= fifo_free) begin
                    launch  = 1'b1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (wbm_ack_i && (beats_q == BW'(1))) begin
                    state_d = (remaining_q == 32'd1) ? S_DRAIN : S_REQ;
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !out_valid_q) begin
                    set_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Master bus datapath: address, remaining words, beat counter, cyc/stb.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr_q       <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            cyc_q       <= 1'b0;
        end else begin
            if (begin_xfer) begin
                adr_q       <= cfg_addr_q;
                remaining_q <= cfg_len_q;
            end else if (beat_ack) begin
                adr_q       <= adr_q + WB_AW'(4);
                remaining_q <= remaining_q - 32'd1;
            end
            if (launch) begin
                cyc_q   <= 1'b1;
                beats_q <= burst_n[BW-1:0];
            end else if (beat_ack) begin
                beats_q <= beats_q - BW'(1);
                if (beats_q == BW'(1)) cyc_q <= 1'b0;
            end
        end
    end

    // FIFO storage; no reset so it maps onto block RAM.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
    end

    // FIFO pointers and the output register that presents the stream head.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                out_q       <= mem[rd_ptr_q[FIFO_AW-1:0]];
                out_valid_q <= 1'b1;
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end else if (m_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Config slave: single-cycle ack with read data, register writes, status.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_en_q   <= 1'b0;
            cfg_addr_q <= '0;
            cfg_len_q  <= '0;
            done_q     <= 1'b0;
            count_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ack_q <= req;
            if (req) begin
                case (reg_sel)
                    3'd0:    rdata_q <= {30'd0, irq_en_q, 1'b0};
                    3'd1:    rdata_q <= {30'd0, done_q, busy};
                    3'd2:    rdata_q <= 32'(cfg_addr_q);
                    3'd3:    rdata_q <= cfg_len_q;
                    3'd4:    rdata_q <= count_q;
                    default: rdata_q <= '0;
                endcase
            end
            if (wr_en) begin
                case (reg_sel)
                    3'd0: irq_en_q <= wbs_dat_i[1];
                    3'd2: if (!busy) cfg_addr_q <= wbs_dat_i[WB_AW-1:0] & ~WB_AW'(3);
                    3'd3: if (!busy) cfg_len_q <= wbs_dat_i;
                    default: ;
                endcase
            end
            if (set_done)                                          done_q <= 1'b1;
            else if (wr_en && (reg_sel == 3'd1) && wbs_dat_i[1])   done_q <= 1'b0;
            if (begin_xfer) count_q <= '0;
            else if (xfer)  count_q <= count_q + 32'd1;
            irq_q <= done_q & irq_en_q;
        end
    end
endmodule

// File: tb/tb_wb_mem_streamer.sv
// Randomized scoreboard bench for wb_mem_streamer (FIFO_AW=3, BURST_LEN=8).
module tb_wb_mem_streamer;
    logic        clk, rst_n;
    logic [4:0]  wbs_adr;
    logic [31:0] wbs_dat_w, wbs_dat_r;
    logic        wbs_we, wbs_cyc, wbs_stb, wbs_ack;
    logic [31:0] wbm_adr, wbm_dat;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [3:0]  wbm_sel;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic [31:0] m_data;
    logic        m_valid, m_ready, irq;
`ifdef MEM_STREAMER_LAST_EN
    logic        m_last;
`endif

    wb_mem_streamer #(.WB_AW(32), .FIFO_AW(3), .BURST_LEN(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_w), .wbs_we_i(wbs_we),
        .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_dat_o(wbs_dat_r), .wbs_ack_o(wbs_ack),
        .wbm_adr_o(wbm_adr), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
        .wbm_sel_o(wbm_sel), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
        .wbm_dat_i(wbm_dat), .wbm_ack_i(wbm_ack),
        .m_data_o(m_data), .m_valid_o(m_valid),
`ifdef MEM_STREAMER_LAST_EN
        .m_last_o(m_last),
`endif
        .m_ready_i(m_ready), .irq_o(irq)
    );

    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    typedef struct packed { logic [31:0] adr; logic [2:0] cti; } beat_t;
    exp_t  stream_q[$];
    beat_t bus_q[$];

    int checks = 0, failures = 0;
    int ack_count = 0, cyc_cycles = 0, word_idx = 0;
    int ready_mode = 1;
    logic [31:0] mem_seed;
    logic [31:0] rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ mem_seed;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected stream and bus beats derived directly from the transfer rules.
    task automatic expect_transfer(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int rem, n;
        for (int i = 0; i < len; i++) begin
            a = addr + 32'(4 * i);
            stream_q.push_back('{data: mem_word(a), last: (i == len - 1)});
        end
        a = addr;
        rem = len;
        while (rem > 0) begin
            n = (rem < 8) ? rem : 8;
            for (int j = 0; j < n; j++) begin
                bus_q.push_back('{adr: a, cti: (j == n - 1) ? 3'b111 : 3'b010});
                a = a + 32'd4;
            end
            rem -= n;
        end
    endtask

    task automatic wbs_xfer(input logic [2:0] r, input logic we, input logic [31:0] wd,
                            output logic [31:0] rdata);
        bit got = 0;
        @(posedge clk); #1;
        wbs_adr = {r, 2'b00}; wbs_dat_w = wd; wbs_we = we; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack) begin rdata = wbs_dat_r; got = 1; break; end
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL wbs_ack_timeout actual=0 required=1");
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wbs_xfer(r, 1'b1, d, dummy);
    endtask

    task automatic rdreg(input logic [2:0] r, output logic [31:0] d);
        wbs_xfer(r, 1'b0, 32'd0, d);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            rdreg(3'd1, s);
            if (s[1]) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done_timeout actual=%h required=2", name, s);
        end
    endtask

    task automatic run_transfer(input string name, input logic [31:0] addr, input int len, input int mode);
        logic [31:0] v;
        wr(3'd1, 32'h2);
        ready_mode = mode;
        wr(3'd2, addr);
        wr(3'd3, 32'(len));
        expect_transfer(addr, len);
        wr(3'd0, 32'h3);
        wait_done(name);
        rdreg(3'd4, v);           check({name, "_count"}, v, 32'(len));
        rdreg(3'd1, v);           check({name, "_status"}, v, 32'h2);
        check({name, "_irq"}, {31'd0, irq}, 32'd1);
        check({name, "_stream_left"}, 32'(stream_q.size()), 32'd0);
        check({name, "_bus_left"}, 32'(bus_q.size()), 32'd0);
        $display("transfer %s addr=%h len=%0d complete", name, addr, len);
    endtask

    // Memory slave: random wait states, data computed from the beat address.
    initial begin
        wbm_ack = 1'b0; wbm_dat = '0;
        forever begin
            @(posedge clk); #1;
            wbm_ack = wbm_cyc && wbm_stb && ($urandom_range(0, 2) != 0);
            wbm_dat = mem_word(wbm_adr);
        end
    end

    // Stream sink ready pattern.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stream words and bus beats against the scoreboard queues.
    initial begin
        exp_t  e;
        beat_t b;
        bit prev_hold = 0;
        logic [31:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", {31'd0, m_valid}, 32'd1);
                    check("hold_data", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (stream_q.size() == 0) begin
                        failures++;
                        $display("FAIL stream_extra actual=%h required=no_word", m_data);
                    end else begin
                        checks--;
                        e = stream_q.pop_front();
                        check("stream_data", m_data, e.data);
`ifdef MEM_STREAMER_LAST_EN
                        check("stream_last", {31'd0, m_last}, {31'd0, e.last});
`endif
                        $display("stream word %0d data=%h", word_idx, m_data);
                        word_idx++;
                    end
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
                if (wbm_cyc) cyc_cycles++;
                if (wbm_cyc && wbm_stb && wbm_ack) begin
                    ack_count++;
                    checks++;
                    if (bus_q.size() == 0) begin
                        failures++;
                        $display("FAIL bus_extra actual=%h required=no_beat", wbm_adr);
                    end else begin
                        checks--;
                        b = bus_q.pop_front();
                        check("bus_adr", wbm_adr, b.adr);
                        check("bus_cti", {29'd0, wbm_cti}, {29'd0, b.cti});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] v, a;
        int base, cyc0, len;
        bit hit;
        mem_seed = $urandom;
        rst_n = 1'b0;
        wbs_adr = '0; wbs_dat_w = '0; wbs_we = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
        check("rst_stb", {31'd0, wbm_stb}, 32'd0);
        check("rst_cti", {29'd0, wbm_cti}, 32'd0);
        check("rst_adr", wbm_adr, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, wbs_ack}, 32'd0);
        check("tie_we_sel_bte", {25'd0, wbm_we, wbm_sel, wbm_bte}, {25'd0, 1'b0, 4'hF, 2'b00});
        @(posedge clk); #3 rst_n = 1'b1;
        rdreg(3'd1, v); check("rst_status", v, 32'd0);
        rdreg(3'd4, v); check("rst_count", v, 32'd0);

        // Single full burst, then W1C DONE clears the interrupt.
        run_transfer("len8", 32'h1000, 8, 1);
        wr(3'd1, 32'h2);
        repeat (2) @(posedge clk);
        #1 check("w1c_irq", {31'd0, irq}, 32'd0);

        // Two bursts: 8 then 3.
        run_transfer("len11", 32'h1000, 11, 2);

        // Backpressure: only one burst fits, then bus stays idle.
        wr(3'd1, 32'h2);
        ready_mode = 0;
        a = 32'h0000_2000;
        wr(3'd2, a); wr(3'd3, 32'd32);
        expect_transfer(a, 32);
        base = ack_count;
        wr(3'd0, 32'h3);
        repeat (300) @(posedge clk);
        #1;
        check("stall_acks", 32'(ack_count - base), 32'd8);
        check("stall_cyc", {31'd0, wbm_cyc}, 32'd0);
        wr(3'd2, 32'h5555_0000); wr(3'd3, 32'd5); wr(3'd0, 32'h3);
        rdreg(3'd2, v); check("busy_addr", v, a);
        rdreg(3'd3, v); check("busy_len", v, 32'd32);
        rdreg(3'd1, v); check("busy_status", v, 32'h1);
        ready_mode = 2;
        wait_done("stall");
        rdreg(3'd4, v); check("stall_count", v, 32'd32);
        check("stall_stream_left", 32'(stream_q.size()), 32'd0);

        // Zero length: DONE with no bus activity.
        wr(3'd1, 32'h2);
        repeat (2) @(posedge clk);
        wr(3'd3, 32'd0);
        cyc0 = cyc_cycles;
        wr(3'd0, 32'h3);
        @(posedge clk); #1;
        check("len0_irq", {31'd0, irq}, 32'd1);
        rdreg(3'd1, v); check("len0_status", v, 32'h2);
        check("len0_cyc", 32'(cyc_cycles - cyc0), 32'd0);

        // Random transfers, including one across the address wrap.
        for (int t = 0; t < 5; t++) begin
            a = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            len = $urandom_range(1, 40);
            run_transfer($sformatf("rand%0d", t), a, len, 2);
        end

        // Reset in the middle of a burst.
        wr(3'd1, 32'h2);
        ready_mode = 1;
        wr(3'd2, 32'h3000); wr(3'd3, 32'd8);
        expect_transfer(32'h3000, 8);
        base = ack_count;
        wr(3'd0, 32'h3);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack_count - base >= 2) begin hit = 1; break; end
        end
        check("midrst_reached", {31'd0, hit}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cyc", {31'd0, wbm_cyc}, 32'd0);
        check("midrst_stb", {31'd0, wbm_stb}, 32'd0);
        check("midrst_valid", {31'd0, m_valid}, 32'd0);
        stream_q.delete();
        bus_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        rdreg(3'd1, v); check("postrst_status", v, 32'd0);
        rdreg(3'd4, v); check("postrst_count", v, 32'd0);
        wr(3'd0, 32'h2);
        run_transfer("postrst", 32'h3000, 8, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule
